// File: rtl/morse_pkg.sv
// morse_pkg
//   Shared types and helpers for the Morse symbol transmitter.
//   - state_t   : sequencer states (IDLE, MARK, SPACE, DONE)
//   - ELEM_DOT / ELEM_DASH : element encoding inside a pattern word
//   - clamp_len : limits a requested element count to the register size
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  // Lengths above the register size are treated as a full-length symbol.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/morse_symbol_transmitter_if.sv
// morse_symbol_transmitter_if
//   Request/status bundle between the letter-select logic and the
//   transmitter.
//   - start   : request to transmit (master -> slave)
//   - pattern : right-aligned elements, 1 = dash (master -> slave)
//   - length  : number of valid elements (master -> slave)
//   - busy    : transmission in progress (slave -> master)
//   - led     : Morse output, high during a mark (slave -> master)
//   - done    : one-cycle completion pulse (slave -> master)
interface morse_symbol_transmitter_if #(
  parameter int MAX_LEN = 4
) ();

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
  logic               busy;
  logic               led;
  logic               done;

  modport master (
    output start, pattern, length,
    input  busy, led, done
  );

  modport slave (
    input  start, pattern, length,
    output busy, led, done
  );

endinterface

// File: rtl/morse_unit_timer.sv
// morse_unit_timer
//   Loadable down-counter used to time marks and gaps.
//   - clk        : system clock, rising edge
//   - reset      : synchronous, active-low; clears the count
//   - load       : load load_value this cycle (takes priority)
//   - load_value : start value; a load of N-1 gives N cycles until zero
//   - zero       : count is zero (counter holds at zero)
module morse_unit_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/morse_symbol_transmitter.sv
// morse_symbol_transmitter
//   Plays a dot/dash pattern MSB-first on a single LED with unit-based
//   timing. The requested field is left-aligned at load so the element
//   to send is always shift_reg[MAX_LEN-1].
//   - clk   : system clock, rising edge
//   - reset : synchronous, active-low; aborts any transmission silently
//   - sym   : slave side of the start/busy/done bundle plus led output
//   Outputs are decoded from the registered state only.
module morse_symbol_transmitter
  import morse_pkg::*;
#(
  parameter int MAX_LEN     = 4,
  parameter int UNIT_CYCLES = 25000000,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  morse_symbol_transmitter_if.slave   sym
);

  localparam int LEN_W       = $clog2(MAX_LEN + 1);
  localparam int DASH_CYCLES = DASH_UNITS * UNIT_CYCLES;
  // Guard against a zero-width counter when a dash is a single cycle.
  localparam int CNT_W       = (DASH_CYCLES > 1) ? $clog2(DASH_CYCLES) : 1;

  // The timer is sized for the longest interval, a dash; GAP_UNITS is
  // expected not to exceed DASH_UNITS.
  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_UNITS * UNIT_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] shift_reg, shift_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] load_pattern;

  logic               timer_load;
  logic [CNT_W-1:0]   timer_value;
  logic               timer_zero;

  function automatic logic [CNT_W-1:0] mark_load(input logic elem);
    return (elem == ELEM_DASH) ? DASH_LOAD : DOT_LOAD;
  endfunction

  // Left-align the valid field so the first element lands in the MSB and
  // unused low bits read as zero.
  assign eff_len      = LEN_W'(clamp_len(int'(sym.length), MAX_LEN));
  assign load_pattern = sym.pattern << (MAX_LEN - int'(eff_len));

  morse_unit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    remaining_next = remaining_reg;
    timer_load     = 1'b0;
    timer_value    = '0;

    case (state_reg)
      IDLE: begin
        if (sym.start) begin
          shift_next     = load_pattern;
          remaining_next = eff_len;
          if (eff_len == '0) begin
            state_next = DONE;
          end else begin
            state_next  = MARK;
            timer_load  = 1'b1;
            timer_value = mark_load(load_pattern[MAX_LEN-1]);
          end
        end
      end

      MARK: begin
        if (timer_zero) begin
          shift_next     = shift_reg << 1;
          remaining_next = remaining_reg - LEN_W'(1);
          // The last element ends straight into DONE: no trailing gap.
          if (remaining_reg == LEN_W'(1)) begin
            state_next = DONE;
          end else begin
            state_next  = SPACE;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
          end
        end
      end

      SPACE: begin
        if (timer_zero) begin
          // shift_reg was advanced at the end of the mark, so its MSB is
          // already the next element.
          state_next  = MARK;
          timer_load  = 1'b1;
          timer_value = mark_load(shift_reg[MAX_LEN-1]);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sym.led  = (state_reg == MARK);
  assign sym.busy = (state_reg != IDLE);
  assign sym.done = (state_reg == DONE);

endmodule

// File: doc/morse_symbol_transmitter.md
Name: morse_symbol_transmitter

Overview:
Parametrised Morse element sequencer for the lab display path.
- Accepts a right-aligned dot/dash pattern and its length through a start/busy/done handshake.
- Left-aligns the valid field, then plays it MSB-first on a single LED output with unit-based timing (dot, dash, inter-element gap).
- Driven by the letter-select logic. Replaces the fixed 4-element load-only shifter with a timed, clocked transmitter.

Parameters:
- MAX_LEN, 4, maximum number of elements per symbol.
- UNIT_CYCLES, 25000000, clock cycles per Morse unit (0.5 s at 50 MHz).
- DASH_UNITS, 3, dash length in units (dot is fixed at 1 unit).
- GAP_UNITS, 1, inter-element gap in units.
- LEN_W, $clog2(MAX_LEN+1), width of the length port (derived, not overridden).
- CNT_W, $clog2(DASH_UNITS*UNIT_CYCLES), timer width (derived).

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- reset, input, 1, synchronous, active-low reset.
- start, input, 1, request to transmit; sampled only in IDLE.
- pattern, input, MAX_LEN, elements right-aligned; bit 1 = dash, 0 = dot; pattern[length-1] is sent first.
- length, input, LEN_W, number of valid elements, 0..2^LEN_W-1.
- busy, output, 1, high from the cycle after an accepted start through the DONE cycle.
- led, output, 1, Morse output; high during a mark.
- done, output, 1, one-cycle pulse when the symbol completes.

Behaviour:
- Reset (reset==0 at a clock edge): next state IDLE; led=0, busy=0, done=0; shift register, element counter and timer all cleared. Reset applies in any state and aborts a transmission mid-mark or mid-gap; no done pulse is generated.
- Length clamping: eff_len = min(length, MAX_LEN).
- Load: shift_reg <= pattern << (MAX_LEN - eff_len). This makes shift_reg[MAX_LEN-1] the first element; unused low bits become 0.
- States: IDLE, MARK, SPACE, DONE (one-hot or binary, designer's choice).
- IDLE: led=0, busy=0, done=0.
  - start=1 at edge N: load shift_reg, remaining<=eff_len.
  - If eff_len==0: go to DONE.
  - Otherwise: go to MARK, with timer <= (msb ? DASH_UNITS : 1)*UNIT_CYCLES - 1.
  - start=0: stay in IDLE.
- MARK: led=1, busy=1.
  - Timer decrements each cycle.
  - At timer==0: shift_reg <= shift_reg << 1; remaining <= remaining - 1.
  - If remaining==1: go to DONE.
  - Otherwise: go to SPACE, with timer <= GAP_UNITS*UNIT_CYCLES - 1.
- SPACE: led=0, busy=1.
  - Timer decrements each cycle.
  - At timer==0: go to MARK, with timer loaded from the new msb as in IDLE.
- DONE: led=0, busy=1, done=1 for exactly one cycle, then IDLE unconditionally.
  - No trailing gap is generated; the caller inserts inter-letter spacing.
- Latency: for a start accepted at edge N, led rises in cycle N+1. A dot holds led high for exactly UNIT_CYCLES cycles; a dash holds it for DASH_UNITS*UNIT_CYCLES cycles.
- start while busy (MARK, SPACE or DONE) is ignored: no reload and no restart. pattern and length are don't-care outside the IDLE start cycle.
- start asserted in the cycle immediately after DONE, with the FSM back in IDLE, is accepted normally. Back-to-back symbols therefore have a 1-cycle dead gap.
- done and led are never high in the same cycle.
- All outputs are registered or decoded purely from the registered state; no combinational path from any input to any output.

Decomposition:
- Package morse_pkg:
  - state enum {IDLE, MARK, SPACE, DONE};
  - constants ELEM_DOT=1'b0, ELEM_DASH=1'b1;
  - function clamp_len.
- One natural sub-module: morse_unit_timer, a loadable down-counter of width CNT_W with load, load_value and a zero flag. The main FSM instantiates one copy.
- The shift register and element counter stay in the top module.

Test Plan:
All scenarios use UNIT_CYCLES=2, DASH_UNITS=3, GAP_UNITS=1, MAX_LEN=4.
- Letter A: pattern=4'b0001, length=2, start pulse at cycle 0 -> led high cycles 1-2, low 3-4, high 5-10; done=1 at cycle 11; busy high cycles 1-11; back in IDLE at cycle 12.
- Letter Q: pattern=4'b1101, length=4 -> led marks of 6, 6, 2, 6 cycles, each separated by 2-cycle gaps; done one cycle after the last mark; total busy 27 cycles.
- length=0, start -> done=1 at cycle 1, led never high, busy high only at cycle 1.
- length=7, pattern=4'b0110 -> clamped to 4, elements dot, dash, dash, dot (2, 6, 6, 2-cycle marks).
- start re-pulsed with a different pattern during MARK and during SPACE -> waveform identical to the no-repulse case.
- reset=0 at cycle 4 of a dash -> next cycle led=0, busy=0, done never pulses; a fresh start is then accepted and plays correctly.
